// File: rtl/mmio_led_pwm_if.sv
// Word-wide load/store bus between the CPU datapath and the LED/RGB PWM responder.
// Strobe semantics: wr_en/rd_en are single-cycle strobes qualified by hit (a combinational decode of addr); a
// store lands on that edge, and a load answers with rd_valid=1 and rd_data exactly one cycle later, with no backpressure.
interface mmio_led_pwm_if;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        hit;

  modport master (output addr, wr_en, wr_data, rd_en, input rd_data, rd_valid, hit);
  modport slave  (input addr, wr_en, wr_data, rd_en, output rd_data, rd_valid, hit);
endinterface

// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED/RGB PWM block: 8-word register window, shadowed duty registers,
// prescaled PWM counter and registered active-high channel outputs (led, red, green, blue).
module mmio_led_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PWM_BITS  = 8,
  parameter int          PRESCALE  = 47
) (
  input  logic            clk,
  input  logic            reset,
  mmio_led_pwm_if.slave   bus,
  output logic            led,
  output logic            red,
  output logic            green,
  output logic            blue
);

  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PRESCALE);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LED    = 3'd1;
  localparam logic [2:0] A_R      = 3'd2;
  localparam logic [2:0] A_G      = 3'd3;
  localparam logic [2:0] A_B      = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [1:0]                    ctrl_q, ctrl_d;
  logic [3:0][PWM_BITS-1:0]      duty_q, duty_d;
  logic [3:0][PWM_BITS-1:0]      act_q, act_d;
  logic [PRE_W-1:0]              pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]           pwm_cnt_q, pwm_cnt_d;
  logic                          period_done_q, period_done_d;
  logic [31:0]                   rd_data_q, rd_data_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [3:0]                    out_q, out_d;

  logic [31:0] addr_w;
  logic [31:0] offset;
  logic [2:0]  idx;
  logic        wr_hit, rd_hit;
  logic        tick, wrap;
  logic        enable, invert_all;
  logic [31:0] rdata;

  // Byte lanes are ignored, so decode on the word-aligned address.
  assign addr_w  = {bus.addr[31:2], 2'b00};
  assign offset  = addr_w - BASE_ADDR;
  assign idx     = offset[4:2];
  assign bus.hit = (addr_w >= BASE_ADDR) && (offset <= 32'h0000_001C);
  assign wr_hit  = bus.wr_en & bus.hit;
  assign rd_hit  = bus.rd_en & bus.hit;

  assign tick       = (pre_cnt_q == PRE_MAX);
  assign wrap       = tick & (pwm_cnt_q == CNT_MAX);
  assign enable     = ctrl_q[0];
  assign invert_all = ctrl_q[1];

  always_comb begin
    rdata = '0;
    case (idx)
      A_CTRL:   rdata[1:0]          = ctrl_q;
      A_LED:    rdata[PWM_BITS-1:0] = duty_q[0];
      A_R:      rdata[PWM_BITS-1:0] = duty_q[1];
      A_G:      rdata[PWM_BITS-1:0] = duty_q[2];
      A_B:      rdata[PWM_BITS-1:0] = duty_q[3];
      A_STATUS: begin
        rdata[PWM_BITS-1:0] = pwm_cnt_q;
        rdata[16]           = period_done_q;
      end
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_d        = ctrl_q;
    duty_d        = duty_q;
    act_d         = act_q;
    pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    period_done_d = period_done_q;
    rd_data_d     = rd_hit ? rdata : '0;
    rd_valid_d    = rd_hit;
    out_d         = '0;

    if (wr_hit) begin
      case (idx)
        A_CTRL:   ctrl_d    = bus.wr_data[1:0];
        A_LED:    duty_d[0] = bus.wr_data[PWM_BITS-1:0];
        A_R:      duty_d[1] = bus.wr_data[PWM_BITS-1:0];
        A_G:      duty_d[2] = bus.wr_data[PWM_BITS-1:0];
        A_B:      duty_d[3] = bus.wr_data[PWM_BITS-1:0];
        A_STATUS: if (bus.wr_data[16]) period_done_d = 1'b0;
        default:  ;
      endcase
    end

    // Shadow load uses the pre-write programmed value, so a coincident store waits a period.
    if (wrap) begin
      act_d         = duty_q;
      period_done_d = 1'b1;
    end

    for (int i = 0; i < 4; i++) begin
      out_d[i] = (enable & (pwm_cnt_q < act_q[i])) ^ (enable & invert_all);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      duty_q        <= '0;
      act_q         <= '0;
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      period_done_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      out_q         <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      act_q         <= act_d;
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      period_done_q <= period_done_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      out_q         <= out_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign led   = out_q[0];
  assign red   = out_q[1];
  assign green = out_q[2];
  assign blue  = out_q[3];

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Directed bench for mmio_led_pwm (PRESCALE=0, PWM_BITS=8): register-map vector table
// followed by hand-written PWM, shadowing, period_done and reset sequences.
module tb_mmio_led_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic reset;
  logic led, red, green, blue;

  mmio_led_pwm_if bus ();

  mmio_led_pwm #(
    .BASE_ADDR (BASE),
    .PWM_BITS  (8),
    .PRESCALE  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always #5 clk = ~clk;

  // Reference PWM counter: with PRESCALE=0 it advances every clock after reset.
  logic [7:0] m_cnt;
  always @(posedge clk) begin
    if (reset) m_cnt <= '0;
    else       m_cnt <= m_cnt + 8'd1;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic        is_status;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.addr    = '0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic v,
                         output logic [7:0] cnt);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    cnt       = m_cnt;
    @(negedge clk);
    d         = bus.rd_data;
    v         = bus.rd_valid;
    bus.rd_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    logic [7:0]  c;
    do_read(a, d, v, c);
    check({name, "_valid"}, 32'(v), 32'd1);
    check(name, d, exp);
  endtask

  task automatic status_check(input string name, input logic exp_pd);
    logic [31:0] d;
    logic        v;
    logic [7:0]  c;
    do_read(BASE + 32'h14, d, v, c);
    check({name, "_valid"}, 32'(v), 32'd1);
    check(name, d, {15'b0, exp_pd, 8'b0, c});
  endtask

  task automatic wait_cnt(input logic [7:0] target);
    int k;
    k = 0;
    @(negedge clk);
    while (m_cnt != target && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (m_cnt != target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_cnt timeout: counter 0x%02h never reached 0x%02h", m_cnt, target);
    end
  endtask

  task automatic count_high(input int n, output int cl, output int cr, output int cg, output int cb);
    cl = 0; cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cl += int'(led);
      cr += int'(red);
      cg += int'(green);
      cb += int'(blue);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    int cl, cr, cg, cb;

    //            addr           wr    wdata          rd    st    exp_rd         val   hit
    vt[0]  = '{BASE + 32'h00, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[1]  = '{BASE + 32'h04, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[2]  = '{BASE + 32'h08, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[3]  = '{BASE + 32'h0C, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[4]  = '{BASE + 32'h10, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[5]  = '{BASE + 32'h14, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1};
    vt[6]  = '{BASE + 32'h18, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[7]  = '{BASE + 32'h1C, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[8]  = '{BASE + 32'h04, 1'b1, 32'h0000_01FF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[9]  = '{BASE + 32'h04, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_00FF, 1'b1, 1'b1};
    vt[10] = '{BASE + 32'h08, 1'b1, 32'h0000_0055, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[11] = '{BASE + 32'h08, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0055, 1'b1, 1'b1};
    vt[12] = '{BASE + 32'h00, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[13] = '{BASE + 32'h00, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b1};
    vt[14] = '{BASE + 32'h18, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[15] = '{BASE + 32'h18, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[16] = '{32'hFFFE_FFFC, 1'b1, 32'h0000_00AB, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[17] = '{32'hFFFE_FFFC, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[18] = '{BASE + 32'h20, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
    vt[19] = '{BASE + 32'h07, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_00FF, 1'b1, 1'b1};
    vt[20] = '{BASE + 32'h14, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[21] = '{BASE + 32'h14, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b1};
    vt[22] = '{BASE + 32'h04, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[23] = '{BASE + 32'h04, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};
    vt[24] = '{BASE + 32'h00, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vt[25] = '{BASE + 32'h00, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1};

    bus_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {28'b0, led, red, green, blue}, 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_rd_data", bus.rd_data, 32'h0);
    reset = 1'b0;

    // Register map table: 3 cycles per vector (drive, response, idle).
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.addr    = vt[i].addr;
      bus.wr_en   = vt[i].wr;
      bus.wr_data = vt[i].wdata;
      bus.rd_en   = vt[i].rd;
      exp = vt[i].is_status ? (vt[i].exp_rd | {24'b0, m_cnt}) : vt[i].exp_rd;
      #1;
      check($sformatf("v%0d_hit", i), 32'(bus.hit), 32'(vt[i].exp_hit));
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(bus.rd_valid), 32'(vt[i].exp_valid));
      check($sformatf("v%0d_rdata", i), bus.rd_data, exp);
      bus_idle();
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), 32'(bus.rd_valid), 32'h0);
    end

    // Red at 64/256 once the shadow copy loads; other channels idle.
    do_write(BASE + 32'h00, 32'h1);
    do_write(BASE + 32'h08, 32'h40);
    wait_cnt(8'h00);
    count_high(256, cl, cr, cg, cb);
    check("red_64", 32'(cr), 32'd64);
    check("led_off", 32'(cl), 32'd0);
    check("green_off", 32'(cg), 32'd0);
    check("blue_off", 32'(cb), 32'd0);

    // Green written in the wrap cycle keeps its old duty for one more period.
    do_write(BASE + 32'h0C, 32'h20);
    wait_cnt(8'h00);
    wait_cnt(8'hFF);
    bus.addr    = BASE + 32'h0C;
    bus.wr_data = 32'h80;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    count_high(256, cl, cr, cg, cb);
    check("green_old_duty", 32'(cg), 32'd32);
    check("red_steady1", 32'(cr), 32'd64);
    count_high(256, cl, cr, cg, cb);
    check("green_new_duty", 32'(cg), 32'd128);

    // Blue boundaries, plus invert_all.
    do_write(BASE + 32'h10, 32'hFF);
    wait_cnt(8'h00);
    count_high(256, cl, cr, cg, cb);
    check("blue_ff", 32'(cb), 32'd255);
    do_write(BASE + 32'h00, 32'h3);
    count_high(256, cl, cr, cg, cb);
    check("blue_ff_inv", 32'(cb), 32'd1);
    check("red_inv", 32'(cr), 32'd192);
    check("led_inv", 32'(cl), 32'd256);
    do_write(BASE + 32'h10, 32'h00);
    wait_cnt(8'h00);
    count_high(256, cl, cr, cg, cb);
    check("blue_00_inv", 32'(cb), 32'd256);
    do_write(BASE + 32'h00, 32'h1);
    count_high(256, cl, cr, cg, cb);
    check("blue_00", 32'(cb), 32'd0);
    do_write(BASE + 32'h00, 32'h2);
    count_high(256, cl, cr, cg, cb);
    check("disabled_all_off", 32'(cl + cr + cg + cb), 32'd0);

    // period_done: sticky, W1C, set wins over a coincident clear.
    status_check("pd_set", 1'b1);
    wait_cnt(8'h0A);
    do_write(BASE + 32'h14, 32'h0001_0000);
    status_check("pd_cleared", 1'b0);
    wait_cnt(8'hFF);
    bus.addr    = BASE + 32'h14;
    bus.wr_data = 32'h0001_0000;
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    status_check("pd_set_wins", 1'b1);
    do_write(BASE + 32'h14, 32'h0000_FFFF);
    status_check("pd_w0_keeps", 1'b1);

    // Reset mid-period with a load pending.
    do_write(BASE + 32'h00, 32'h1);
    do_write(BASE + 32'h08, 32'h80);
    wait_cnt(8'h00);
    wait_cnt(8'h05);
    check("red_high_pre_reset", 32'(red), 32'd1);
    @(negedge clk);
    bus.addr  = BASE + 32'h04;
    bus.rd_en = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {28'b0, led, red, green, blue}, 32'h0);
    check("mid_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("mid_rst_rd_data", bus.rd_data, 32'h0);
    reset     = 1'b0;
    bus.rd_en = 1'b0;
    status_check("post_rst_status", 1'b0);
    read_check("post_rst_ctrl", BASE + 32'h00, 32'h0);
    read_check("post_rst_duty_r", BASE + 32'h08, 32'h0);
    read_check("post_rst_duty_g", BASE + 32'h0C, 32'h0);
    count_high(256, cl, cr, cg, cb);
    check("post_rst_all_off", 32'(cl + cr + cg + cb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
